// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR/JK/D/T flip-flop bank: runtime mode values and
// the policy constants that select the behaviour for S=R=1 in SR mode.
package sr_ff_pkg;

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_e;

   localparam int POL_HOLD = 0;
   localparam int POL_SET  = 1;
   localparam int POL_RST  = 2;

   // Unknown policy values fall back to hold.
   function automatic int effective_policy(input int pol);
      return ((pol == POL_SET) || (pol == POL_RST)) ? pol : POL_HOLD;
   endfunction

endpackage

// File: rtl/sr_ff_bank_ff_cell.sv
// One flip-flop channel: mode-selected next-state function plus its state
// register with enable and synchronous reset. nq is exported for change flags.
module ff_cell
   import sr_ff_pkg::*;
#(
   parameter logic INIT_BIT  = 1'b0,
   parameter int   SR_POLICY = POL_HOLD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q,
   output logic       nq
);

   localparam int POL_EFF = effective_policy(SR_POLICY);

   logic q_reg;

   always_comb begin
      nq = q_reg;
      case (mode)
         MODE_SR: begin
            if (a && !b)
               nq = 1'b1;
            else if (!a && b)
               nq = 1'b0;
            else if (a && b) begin
               if (POL_EFF == POL_SET)
                  nq = 1'b1;
               else if (POL_EFF == POL_RST)
                  nq = 1'b0;
               else
                  nq = q_reg;
            end
         end
         MODE_JK: begin
            if (a && !b)
               nq = 1'b1;
            else if (!a && b)
               nq = 1'b0;
            else if (a && b)
               nq = ~q_reg;
         end
         MODE_D:  nq = a;
         MODE_T:  nq = q_reg ^ a;
         default: nq = q_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         q_reg <= INIT_BIT;
      else if (en)
         q_reg <= nq;
   end

   assign q = q_reg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH flip-flop channels sharing a runtime mode, with per-bit change
// flags, an SR conflict pulse and a saturating conflict counter.
module sr_ff_bank
   import sr_ff_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
   parameter int               SR_POLICY = POL_HOLD,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] changed,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   generate
      if ((SR_POLICY < POL_HOLD) || (SR_POLICY > POL_RST)) begin : g_bad_policy
         $warning("sr_ff_bank: SR_POLICY=%0d is illegal, using hold", SR_POLICY);
      end
   endgenerate

   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] changed_reg;
   logic             conflict_reg;
   logic             conflict_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         ff_cell #(
            .INIT_BIT  (INIT[gi]),
            .SR_POLICY (SR_POLICY)
         ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .mode (mode),
            .a    (a[gi]),
            .b    (b[gi]),
            .q    (q[gi]),
            .nq   (nq[gi])
         );
      end
   endgenerate

   // Conflict is reported in SR mode whatever the policy; JK toggles are not conflicts.
   assign conflict_next = en && (mode == MODE_SR) && (|(a & b));

   always_comb begin
      cnt_next = cnt_reg;
      if (clr_cnt)
         cnt_next = '0;
      else if (conflict_next && (cnt_reg != {CNT_W{1'b1}}))
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         changed_reg  <= '0;
         conflict_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         changed_reg  <= en ? (q ^ nq) : '0;
         conflict_reg <= conflict_next;
         cnt_reg      <= cnt_next;
      end
   end

   assign q_bar        = ~q;
   assign changed      = changed_reg;
   assign conflict     = conflict_reg;
   assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed, table-driven check of sr_ff_bank (WIDTH=8, CNT_W=4); two extra
// instances with set- and reset-dominant policies cover the S=R=1 cases.
module tb_sr_ff_bank;

   localparam int W = 8;
   localparam int C = 4;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic       clr;
      logic [W-1:0] eq;
      logic [W-1:0] ech;
      logic       ecf;
      logic [C-1:0] ecnt;
      logic       pol;
      logic [W-1:0] eq_set;
      logic [W-1:0] eq_rst;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b0, clr_cnt = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [W-1:0] a = '0, b = '0;

   logic [W-1:0] q0, qb0, ch0, q1, qb1, ch1, q2, qb2, ch2;
   logic cf0, cf1, cf2;
   logic [C-1:0] cnt0, cnt1, cnt2;

   int n_vec = 0;
   int n_bad = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   sr_ff_bank #(.WIDTH(W), .INIT(8'h00), .SR_POLICY(0), .CNT_W(C)) dut_hold (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
      .q(q0), .q_bar(qb0), .changed(ch0), .conflict(cf0), .conflict_cnt(cnt0));

   sr_ff_bank #(.WIDTH(W), .INIT(8'h00), .SR_POLICY(1), .CNT_W(C)) dut_set (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
      .q(q1), .q_bar(qb1), .changed(ch1), .conflict(cf1), .conflict_cnt(cnt1));

   sr_ff_bank #(.WIDTH(W), .INIT(8'h00), .SR_POLICY(2), .CNT_W(C)) dut_rst (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
      .q(q2), .q_bar(qb2), .changed(ch2), .conflict(cf2), .conflict_cnt(cnt2));

   task automatic add(input string nm, input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] va, input logic [W-1:0] vb, input logic c,
                      input logic [W-1:0] xq, input logic [W-1:0] xch, input logic xcf,
                      input logic [C-1:0] xcnt);
      vec_t v;
      v.name = nm; v.rst = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
      v.eq = xq; v.ech = xch; v.ecf = xcf; v.ecnt = xcnt;
      v.pol = 1'b0; v.eq_set = '0; v.eq_rst = '0;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; en = v.en; mode = v.mode; a = v.a; b = v.b; clr_cnt = v.clr;
      @(posedge clk);
      #1;
      n_vec++;
      chk({v.name, ".q"}, q0, v.eq);
      chk({v.name, ".q_bar"}, qb0, ~v.eq);
      chk({v.name, ".changed"}, ch0, v.ech);
      chk({v.name, ".conflict"}, {7'd0, cf0}, {7'd0, v.ecf});
      chk({v.name, ".cnt"}, {4'd0, cnt0}, {4'd0, v.ecnt});
      if (v.pol) begin
         chk({v.name, ".set_q"}, q1, v.eq_set);
         chk({v.name, ".rst_q"}, q2, v.eq_rst);
         chk({v.name, ".set_cf"}, {7'd0, cf1}, 8'd1);
         chk({v.name, ".rst_cf"}, {7'd0, cf2}, 8'd1);
         chk({v.name, ".set_cnt"}, {4'd0, cnt1}, 8'd1);
         chk({v.name, ".rst_cnt"}, {4'd0, cnt2}, 8'd1);
      end
      $display("vec %-12s rst=%b en=%b mode=%0d a=%h b=%h clr=%b -> q=%h ch=%h cf=%b cnt=%h",
               v.name, v.rst, v.en, v.mode, v.a, v.b, v.clr, q0, ch0, cf0, cnt0);
   endtask

   initial begin
      vec_t v;
      // reset and hold
      add("rst0",    1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'h0);
      add("rst1",    1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'h0);
      add("hold",    0, 0, 2'b00, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 0, 4'h0);
      // SR set / reset / hold
      add("sr_set",  0, 1, 2'b00, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 0, 4'h0);
      add("sr_rst",  0, 1, 2'b00, 8'h00, 8'h03, 0, 8'h0C, 8'h03, 0, 4'h0);
      add("sr_hold", 0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h0C, 8'h00, 0, 4'h0);
      // SR conflict; policy instances checked on this vector
      add("sr_conf", 0, 1, 2'b00, 8'h81, 8'h81, 0, 8'h0C, 8'h00, 1, 4'h1);
      vq[$].pol = 1'b1; vq[$].eq_set = 8'h8D; vq[$].eq_rst = 8'h0C;
      add("cf_drop", 0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h0C, 8'h00, 0, 4'h1);
      // D load, JK toggle, T toggle, disabled hold
      add("d_load",  0, 1, 2'b10, 8'hA5, 8'h00, 0, 8'hA5, 8'hA9, 0, 4'h1);
      add("jk_tog",  0, 1, 2'b01, 8'hFF, 8'hFF, 0, 8'h5A, 8'hFF, 0, 4'h1);
      add("t_tog",   0, 1, 2'b11, 8'h0F, 8'hFF, 0, 8'h55, 8'h0F, 0, 4'h1);
      add("en_off",  0, 0, 2'b11, 8'hFF, 8'hFF, 0, 8'h55, 8'h00, 0, 4'h1);
      add("jk_set",  0, 1, 2'b01, 8'h02, 8'h01, 0, 8'h56, 8'h03, 0, 4'h1);

      foreach (vq[i]) apply(vq[i]);

      // saturating counter: 20 conflict cycles, count climbs from 1 and stops at F
      for (int i = 0; i < 20; i++) begin
         v.name = $sformatf("sat%0d", i); v.rst = 0; v.en = 1; v.mode = 2'b00;
         v.a = 8'h01; v.b = 8'h01; v.clr = 0;
         v.eq = 8'h56; v.ech = 8'h00; v.ecf = 1;
         v.ecnt = (i + 2 > 15) ? 4'hF : 4'(i + 2);
         v.pol = 0; v.eq_set = '0; v.eq_rst = '0;
         apply(v);
      end
      // clear wins over a simultaneous conflict, next conflict counts from 0
      v.name = "clr_conf"; v.clr = 1; v.ecnt = 4'h0; apply(v);
      v.name = "after_clr"; v.clr = 0; v.ecnt = 4'h1; apply(v);
      // clear still works while disabled
      v.name = "clr_dis"; v.en = 0; v.clr = 1; v.ecf = 0; v.ecnt = 4'h0; apply(v);

      // reset overrides an enabled D load on the same edge
      v.name = "mid_rst"; v.rst = 1; v.en = 1; v.mode = 2'b10; v.a = 8'h3C; v.b = 8'h00;
      v.clr = 0; v.eq = 8'h00; v.ech = 8'h00; v.ecf = 0; v.ecnt = 4'h0; apply(v);
      v.name = "post_rst"; v.rst = 0; v.eq = 8'h3C; v.ech = 8'h3C; apply(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised successor to the single SR flip-flop: a bank of WIDTH independent flip-flop channels sharing one clock.
- A runtime mode selects SR, JK, D or T next-state behaviour for all channels.
- The S=R=1 case has a defined, parameter-selected policy instead of being left undefined.
- Adds clock enable, per-bit change flags, a conflict pulse and a saturating conflict counter.
- Used as a general control/status register bank in the summer-camp designs.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- INIT, {WIDTH{1'b0}}, value loaded into q on reset.
- SR_POLICY, 0, action in SR mode when a=b=1: 0 = hold, 1 = set-dominant, 2 = reset-dominant.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, update enable; when 0 the bank holds.
- mode, input, 2, 00 = SR, 01 = JK, 10 = D, 11 = T.
- a, input, WIDTH, per-channel S / J / D / T input.
- b, input, WIDTH, per-channel R / K input; ignored in D and T modes.
- clr_cnt, input, 1, synchronous clear of conflict_cnt.
- q, output, WIDTH, registered state.
- q_bar, output, WIDTH, combinational ~q.
- changed, output, WIDTH, registered; bit i = 1 if q[i] changed on the last edge.
- conflict, output, 1, registered pulse; 1 if the last enabled SR-mode update had any a[i]&b[i].
- conflict_cnt, output, CNT_W, saturating count of conflict cycles.

Behaviour:
- All state updates on the rising edge of clk. Output latency is 1 cycle from a/b/mode/en to q, changed and conflict.
- Reset (rst=1 at an edge, dominating everything):
  - q = INIT
  - changed = 0
  - conflict = 0
  - conflict_cnt = 0
  - q_bar follows ~INIT.
- Reset asserted mid-operation overrides en, mode and clr_cnt on that edge.
- en=0: q holds, changed = 0, conflict = 0. conflict_cnt holds, except that clr_cnt still clears it.
- en=1, per-bit next state nq[i]:
  - SR mode:
    - a=1, b=0: nq = 1.
    - a=0, b=1: nq = 0.
    - a=0, b=0: nq = q.
    - a=1, b=1: per SR_POLICY (hold / 1 / 0).
  - JK mode:
    - J=1, K=0: nq = 1.
    - J=0, K=1: nq = 0.
    - J=0, K=0: nq = q.
    - J=1, K=1: nq = ~q (toggle, never counted as a conflict).
  - D mode: nq = a.
  - T mode: nq = q ^ a.
- changed <= q ^ nq, computed only when en=1.
- conflict <= en & (mode==SR) & |(a & b). It is asserted regardless of SR_POLICY.
- conflict_cnt:
  - Increments by 1 per cycle in which the conflict condition is true, not per bit.
  - Saturates at all-ones and does not wrap.
  - clr_cnt=1 forces it to 0. If clr_cnt and a conflict occur in the same cycle, the clear wins and the result is 0.
- A mode change takes effect on the same edge it is presented; there is no pipeline flush.
- SR_POLICY values other than 0, 1 or 2 are illegal. They are flagged by an elaboration-time check and treated as hold.

Decomposition:
- Shared package sr_ff_pkg contains:
  - mode encodings MODE_SR, MODE_JK, MODE_D, MODE_T
  - policy constants POL_HOLD, POL_SET, POL_RST.
- Sub-module ff_cell: a one-bit next-state function plus register with en and rst, instantiated WIDTH times in a generate loop.
- The top level contains only the conflict reduction, the counter and the changed register.

Test Plan (WIDTH=8, INIT=8'h00, CNT_W=4):
1. Reset and hold: rst=1 for 2 cycles, then en=0 with a=8'hFF.
   - Required: q=8'h00, q_bar=8'hFF, changed=0, conflict_cnt=0 throughout.
2. SR mode:
   - a=8'h0F, b=0: next cycle q=8'h0F, changed=8'h0F.
   - Then a=0, b=8'h03: q=8'h0C, changed=8'h03.
   - Then a=b=0: q=8'h0C, changed=0.
3. Conflict policy: q=8'h0C, a=b=8'h81, run once for each SR_POLICY build.
   - SR_POLICY=0: q=8'h0C.
   - SR_POLICY=1: q=8'h8D.
   - SR_POLICY=2: q=8'h0C.
   - All builds: conflict=1 for one cycle and conflict_cnt=1.
4. JK and T modes, starting from q=8'hA5:
   - JK mode, a=b=8'hFF: q=8'h5A.
   - T mode, a=8'h0F: q=8'h55, changed=8'h0F.
   - Neither step raises conflict.
5. Counter saturation and clear:
   - Hold the SR conflict for 20 cycles: conflict_cnt stops at 4'hF.
   - clr_cnt=1 together with a conflict: conflict_cnt=0.
   - Next conflict cycle: conflict_cnt=1.
6. Reset mid-operation: D mode, a=8'h3C, with rst=1 and en=1 on the same edge.
   - Required: q=8'h00, changed=0, conflict_cnt=0.
   - Releasing rst gives q=8'h3C on the following edge.
